// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_loader_pkg                                               |
// | Brief    : Shared constants and state encoding for the imem loader.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package imem_loader_pkg;

    localparam int c_depth          = 1024;
    localparam int c_cnt_w          = 16;
    localparam int c_bytes_per_word = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_word_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_word_assembler                                           |
// | Brief    : Packs little-endian bytes into 32-bit words.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic [31:0] o_word_next,
    output logic        o_word_complete
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic [31:0] w_word_next;

    // Shifting in from the top leaves the first byte of a word in bits [7:0]
    // once all four have arrived.
    always_comb begin
        w_word_next = r_word;
        if (i_byte_valid) begin
            w_word_next = {i_byte_data, r_word[31:8]};
        end
    end

    assign o_word_next     = w_word_next;
    assign o_word_complete = i_byte_valid && (r_cnt == 2'(c_bytes_per_word - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_byte_valid) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= w_word_next;
        end
    end

endmodule : imem_word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imem_loader                                                   |
// | Brief    : Loads a length-prefixed byte stream into instruction memory   |
// |            and releases the core from reset when the image is complete.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int CNT_W = c_cnt_w
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        error
);

    localparam logic [CNT_W:0] c_depth_lim = (CNT_W + 1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_n;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  w_hdr_n;
    logic [CNT_W-1:0]  w_idx_inc;
    logic              r_in_ready;
    logic              r_we;
    logic [31:0]       r_wa;
    logic [31:0]       r_wd;
    logic              r_cpu_rst_n;
    logic              r_done;
    logic              r_error;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_asm_valid;
    logic              w_word_complete;
    logic [31:0]       w_word_next;

    assign w_accept    = in_valid && r_in_ready;
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERR));
    assign w_asm_valid = w_accept && (r_state == ST_DATA);
    assign w_idx_inc   = r_idx + CNT_W'(1);

    // Full header as it will be once the high byte currently on the bus lands.
    always_comb begin
        w_hdr_n       = r_n;
        w_hdr_n[15:8] = in_data;
    end

    imem_word_assembler u_asm (
        .clk             (clk),
        .rst             (rst),
        .i_clr           (w_start_ok),
        .i_byte_valid    (w_asm_valid),
        .i_byte_data     (in_data),
        .o_word_next     (w_word_next),
        .o_word_complete (w_word_complete)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (w_accept) w_state_next = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (w_accept) begin
                    if (w_hdr_n == '0) begin
                        w_state_next = ST_DONE;
                    end else if ({1'b0, w_hdr_n} > c_depth_lim) begin
                        w_state_next = ST_ERR;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_word_complete) w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_state_next = (w_idx_inc == r_n) ? ST_DONE : ST_DATA;
            end
            ST_DONE, ST_ERR: begin
                if (start) w_state_next = ST_HDR_LO;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_wa        <= 32'd0;
            r_wd        <= 32'd0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_n         <= '0;
            r_idx       <= '0;
        end else begin
            r_in_ready  <= (w_state_next == ST_HDR_LO) || (w_state_next == ST_HDR_HI) ||
                           (w_state_next == ST_DATA);
            r_we        <= (w_state_next == ST_WRITE);
            r_cpu_rst_n <= (w_state_next == ST_DONE);
            r_done      <= (w_state_next == ST_DONE);
            r_error     <= (w_state_next == ST_ERR);

            if (w_start_ok) begin
                r_n   <= '0;
                r_idx <= '0;
            end else begin
                if ((r_state == ST_HDR_LO) && w_accept) r_n[7:0] <= in_data;
                if ((r_state == ST_HDR_HI) && w_accept) r_n <= w_hdr_n;
                if (r_state == ST_WRITE) r_idx <= w_idx_inc;
            end

            if ((r_state == ST_DATA) && w_word_complete) begin
                r_wa <= 32'(r_idx) << 2;
                r_wd <= w_word_next;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign we        = r_we;
    assign wa        = r_wa;
    assign wd        = r_wd;
    assign cpu_rst_n = r_cpu_rst_n;
    assign done      = r_done;
    assign error     = r_error;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_imem_loader                                                |
// | Brief    : Randomized self-checking bench for imem_loader.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_words [0:DEPTH-1];
    logic [63:0] got_q [$];

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .error     (error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write collector: every strobe is recorded; the input side must be closed.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            got_q.push_back({wa, wd});
            check_eq("rdy_during_wr", 32'(in_ready), 32'd0);
        end
    end

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) exp_words[i] = $urandom;
    endtask

    // Called and returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic with_start);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = with_start;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) begin
            check_eq("rdy_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    function automatic int pick_gap(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // Expected writes: word i of the image lands at byte address 4*i.
    task automatic check_writes(input int n_exp);
        logic [63:0] e;
        check_eq("wr_count", 32'(got_q.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
            e = got_q[i];
            check_eq($sformatf("wa[%0d]", i), e[63:32], 32'(i * 4));
            check_eq($sformatf("wd[%0d]", i), e[31:0], exp_words[i]);
        end
    endtask

    task automatic do_load(input int n, input int glo, input int ghi, input int start_at);
        logic [15:0] hdr;
        hdr = 16'(n);
        got_q.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("st_rdy", 32'(in_ready), 32'd1);
        check_eq("st_rstn", 32'(cpu_rst_n), 32'd0);
        check_eq("st_done", 32'(done), 32'd0);
        check_eq("st_err", 32'(error), 32'd0);
        send_byte(hdr[7:0], pick_gap(glo, ghi), 1'b0);
        send_byte(hdr[15:8], pick_gap(glo, ghi), 1'b0);
        if (n == 0) begin
            @(negedge clk);
            check_eq("n0_done", 32'(done), 32'd1);
            check_eq("n0_rstn", 32'(cpu_rst_n), 32'd1);
            check_eq("n0_rdy", 32'(in_ready), 32'd0);
        end else if (n > DEPTH) begin
            @(negedge clk);
            check_eq("err_flag", 32'(error), 32'd1);
            check_eq("err_rstn", 32'(cpu_rst_n), 32'd0);
            check_eq("err_done", 32'(done), 32'd0);
            check_eq("err_rdy", 32'(in_ready), 32'd0);
            repeat (3) @(negedge clk);
            check_eq("err_hold", 32'(error), 32'd1);
        end else begin
            for (int i = 0; i < n; i++) begin
                for (int b = 0; b < 4; b++) begin
                    send_byte(exp_words[i][8*b +: 8], pick_gap(glo, ghi), (i * 4 + b) == start_at);
                end
            end
            @(negedge clk);
            check_eq("lat_we", 32'(we), 32'd1);
            check_eq("lat_done0", 32'(done), 32'd0);
            check_eq("lat_rstn0", 32'(cpu_rst_n), 32'd0);
            @(negedge clk);
            check_eq("lat_done1", 32'(done), 32'd1);
            check_eq("lat_rstn1", 32'(cpu_rst_n), 32'd1);
            check_eq("lat_we0", 32'(we), 32'd0);
            check_eq("lat_rdy0", 32'(in_ready), 32'd0);
        end
        check_writes((n >= 1 && n <= DEPTH) ? n : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_we"}, 32'(we), 32'd0);
        check_eq({tag, "_wa"}, wa, 32'd0);
        check_eq({tag, "_wd"}, wd, 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(error), 32'd0);
        check_eq({tag, "_rstn"}, 32'(cpu_rst_n), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;

        // Three-instruction image streamed back-to-back.
        exp_words[0] = 32'h0000_02B3;
        exp_words[1] = 32'h0000_0333;
        exp_words[2] = 32'h0062_8863;
        do_load(3, 0, 0, -1);

        // Valid toggling every other cycle.
        fill_rand(2);
        do_load(2, 1, 1, -1);

        // Oversized header, then recovery with a one-word image.
        do_load(DEPTH + 1, 0, 0, -1);
        fill_rand(1);
        do_load(1, 0, 2, -1);

        // Empty image.
        do_load(0, 0, 1, -1);

        // Reset in the middle of word 1 of a four-word load.
        fill_rand(4);
        got_q.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        for (int b = 0; b < 4; b++) send_byte(exp_words[0][8*b +: 8], 0, 1'b0);
        for (int b = 0; b < 2; b++) send_byte(exp_words[1][8*b +: 8], 0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_writes(1);
        fill_rand(5);
        do_load(5, 0, 2, -1);

        // start pulsed while in DATA must not disturb the load.
        fill_rand(3);
        do_load(3, 0, 0, 5);

        // A few randomized images.
        for (int k = 0; k < 4; k++) begin
            int n;
            n = pick_gap(1, 8);
            fill_rand(n);
            do_load(n, 0, 3, -1);
        end

        // Full-depth image; last word lands at 0xFFC.
        fill_rand(DEPTH);
        do_load(DEPTH, 0, 0, -1);
        if (got_q.size() == DEPTH) check_eq("last_wa", got_q[DEPTH-1][63:32], 32'h0000_0FFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule : tb_imem_loader
`default_nettype wire
